// File: rtl/ir_writer.sv
// Pulse-width IR transmitter: sends a start mark, a gap, then one
// width-coded mark (short = 0, long = 1) and gap per data bit, LSB first.
module ir_writer #(
    parameter int DATA_W   = 8,
    parameter int TICK_DIV = 1,
    parameter int START_W  = 14,
    parameter int ZERO_W   = 5,
    parameter int ONE_W    = 10,
    parameter int GAP_W    = 5,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic              rdy,
    output logic              ir,
    output logic              done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_W - 1);
    localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(ZERO_W - 1);
    localparam logic [CNT_W-1:0] ONE_LAST   = CNT_W'(ONE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
    localparam logic [BIT_W-1:0] BIT_DONE   = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SGAP,
        MARK,
        SPACE
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0]    width_q, width_d;
    logic [BIT_W-1:0]    bits_q, bits_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                ir_q, ir_d;
    logic                done_q, done_d;

    logic                tick;
    logic                seg_end;
    logic [CNT_W-1:0]    width_last;
    logic [BIT_W-1:0]    bits_inc;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            width_q <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            ir_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            width_q <= width_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
        end
    end

    // Last width-counter value of the current segment; a segment ends on the
    // tick where the counter sits at this value.
    always_comb begin
        width_last = '0;
        case (state_q)
            START:       width_last = START_LAST;
            SGAP, SPACE: width_last = GAP_LAST;
            MARK:        width_last = shift_q[0] ? ONE_LAST : ZERO_LAST;
            default:     width_last = '0;
        endcase
    end

    assign tick     = (presc_q == PRE_LAST);
    assign seg_end  = tick && (width_q == width_last);
    assign bits_inc = bits_q + 1'b1;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        width_d = width_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        if (state_q == IDLE) begin
            // Prescaler and width counter held at zero so the frame timing is
            // fixed relative to the accept edge.
            presc_d = '0;
            width_d = '0;
            if (en) begin
                state_d = START;
                shift_d = data;
                bits_d  = '0;
            end
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                width_d = seg_end ? '0 : width_q + 1'b1;
            end
            if (seg_end) begin
                case (state_q)
                    START: state_d = SGAP;
                    SGAP:  state_d = MARK;
                    MARK:  state_d = SPACE;
                    SPACE: begin
                        shift_d = shift_q >> 1;
                        bits_d  = bits_inc;
                        if (bits_inc == BIT_DONE) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = MARK;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        ir_d = (state_d == START) || (state_d == MARK);
    end

    assign rdy  = (state_q == IDLE);
    assign ir   = ir_q;
    assign done = done_q;

endmodule

// File: tb/tb_ir_writer.sv
// Bench for ir_writer: two instances (tick divider 1 and 4) checked every
// cycle against a per-cycle waveform model built from the frame rules.
module tb_ir_writer;

    localparam int START_W = 14;
    localparam int ZERO_W  = 5;
    localparam int ONE_W   = 10;
    localparam int GAP_W   = 5;

    typedef bit lvl_q_t[$];

    logic       clk = 1'b0;
    logic       res_n;
    logic       en1, en4;
    logic [7:0] data1, data4;
    logic       rdy1, ir1, done1;
    logic       rdy4, ir4, done4;

    int checks = 0;
    int errors = 0;

    lvl_q_t q1, q4;
    bit     exp_done1 = 1'b0;
    bit     exp_done4 = 1'b0;
    bit     armed = 1'b0;

    int     run1 = 0;
    int     marks1[$];

    always #5 clk = ~clk;

    ir_writer #(.DATA_W(8), .TICK_DIV(1), .START_W(START_W), .ZERO_W(ZERO_W),
                .ONE_W(ONE_W), .GAP_W(GAP_W), .CNT_W(8)) dut1 (
        .clk(clk), .res_n(res_n), .en(en1), .data(data1),
        .rdy(rdy1), .ir(ir1), .done(done1));

    ir_writer #(.DATA_W(8), .TICK_DIV(4), .START_W(START_W), .ZERO_W(ZERO_W),
                .ONE_W(ONE_W), .GAP_W(GAP_W), .CNT_W(8)) dut4 (
        .clk(clk), .res_n(res_n), .en(en4), .data(data4),
        .rdy(rdy4), .ir(ir4), .done(done4));

    // Expected ir level for every clock of a frame, starting with the cycle
    // right after the accept edge.
    function automatic lvl_q_t build_frame(input logic [7:0] d, input int td);
        lvl_q_t f;
        int     mw;
        for (int i = 0; i < START_W * td; i++) f.push_back(1'b1);
        for (int i = 0; i < GAP_W * td; i++)   f.push_back(1'b0);
        for (int b = 0; b < 8; b++) begin
            mw = d[b] ? ONE_W : ZERO_W;
            for (int i = 0; i < mw * td; i++)    f.push_back(1'b1);
            for (int i = 0; i < GAP_W * td; i++) f.push_back(1'b0);
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of levels consumed one per clock.
    always @(posedge clk) begin
        if (!res_n) begin
            q1.delete();
            q4.delete();
            exp_done1 = 1'b0;
            exp_done4 = 1'b0;
            armed     = 1'b1;
        end else begin
            exp_done1 = 1'b0;
            if (q1.size() != 0) begin
                q1.delete(0);
                if (q1.size() == 0) exp_done1 = 1'b1;
            end else if (en1) begin
                q1 = build_frame(data1, 1);
            end
            exp_done4 = 1'b0;
            if (q4.size() != 0) begin
                q4.delete(0);
                if (q4.size() == 0) exp_done4 = 1'b1;
            end else if (en4) begin
                q4 = build_frame(data4, 4);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("ir1",   ir1,   (q1.size() != 0) ? q1[0] : 1'b0);
            checkOutput("rdy1",  rdy1,  q1.size() == 0);
            checkOutput("done1", done1, exp_done1);
            checkOutput("ir4",   ir4,   (q4.size() != 0) ? q4[0] : 1'b0);
            checkOutput("rdy4",  rdy4,  q4.size() == 0);
            checkOutput("done4", done4, exp_done4);
        end
    end

    // Records the length of every completed high run on dut1's ir line.
    always @(negedge clk) begin
        if (ir1 === 1'b1) begin
            run1++;
        end else if (run1 > 0) begin
            marks1.push_back(run1);
            run1 = 0;
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        en1   = 1'b1;
        data1 = d;
        @(negedge clk);
        en1   = 1'b0;
        data1 = 8'($urandom);
    endtask

    task automatic waitDone(input bit four, output int cycles);
        cycles = 0;
        while ((four ? done4 : done1) !== 1'b1 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout actual=none required=done within 3000 cycles");
        end
    endtask

    task automatic checkMarks(input string name, input int exp_w[9]);
        checkOutput({name, "_count"}, marks1.size(), 9);
        for (int i = 0; i < 9; i++)
            checkOutput(name, (i < marks1.size()) ? marks1[i] : 0, exp_w[i]);
    endtask

    initial begin
        int cyc;
        res_n = 1'b0;
        en1 = 1'b0; en4 = 1'b0;
        data1 = 8'h00; data4 = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_ir",   ir1,   0);
        checkOutput("rst_rdy",  rdy1,  1);
        checkOutput("rst_done", done1, 0);
        res_n = 1'b1;

        checkOutput("model_len_00", build_frame(8'h00, 1).size(), 99);
        checkOutput("model_len_ff", build_frame(8'hFF, 1).size(), 139);
        checkOutput("model_len_00_td4", build_frame(8'h00, 4).size(), 396);

        repeat (2) @(negedge clk);
        applyStimulus(8'h00);
        waitDone(1'b0, cyc);
        checkOutput("len_00", cyc, 99);
        checkOutput("rdy_with_done", rdy1, 1);

        repeat (3) @(negedge clk);
        applyStimulus(8'hFF);
        waitDone(1'b0, cyc);
        checkOutput("len_ff", cyc, 139);

        repeat (3) @(negedge clk);
        marks1.delete();
        applyStimulus(8'hA5);
        waitDone(1'b0, cyc);
        checkMarks("marks_a5", '{14, 10, 5, 10, 5, 5, 10, 5, 10});

        repeat (3) @(negedge clk);
        marks1.delete();
        applyStimulus(8'h5A);
        repeat (30) @(negedge clk);
        en1 = 1'b1; data1 = 8'h3C;
        @(negedge clk);
        en1 = 1'b0;
        waitDone(1'b0, cyc);
        checkMarks("marks_busy", '{14, 5, 10, 5, 10, 10, 5, 10, 5});
        repeat (5) @(negedge clk);
        checkOutput("busy_no_extra", rdy1, 1);

        marks1.delete();
        en1 = 1'b1; data1 = 8'h01;
        @(negedge clk);
        data1 = 8'h80;
        waitDone(1'b0, cyc);
        checkOutput("len_01", cyc, 104);
        @(negedge clk);
        checkOutput("b2b_ir", ir1, 1);
        checkOutput("b2b_rdy", rdy1, 0);
        en1 = 1'b0;
        waitDone(1'b0, cyc);
        checkOutput("len_80", cyc, 104);

        repeat (3) @(negedge clk);
        applyStimulus(8'($urandom));
        repeat (40) @(negedge clk);
        res_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ir", ir1, 0);
        checkOutput("midrst_rdy", rdy1, 1);
        checkOutput("midrst_done", done1, 0);
        @(negedge clk);
        res_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midrst_idle", rdy1, 1);
        checkOutput("midrst_noresume", ir1, 0);

        en4 = 1'b1; data4 = 8'h00;
        @(negedge clk);
        en4 = 1'b0;
        waitDone(1'b1, cyc);
        checkOutput("len_00_td4", cyc, 396);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            en1   = ($urandom_range(0, 9) == 0);
            data1 = 8'($urandom);
            en4   = ($urandom_range(0, 9) == 0);
            data4 = 8'($urandom);
            res_n = ($urandom_range(0, 1499) != 0);
        end
        @(negedge clk);
        en1 = 1'b0; en4 = 1'b0; res_n = 1'b1;
        cyc = 0;
        while ((rdy1 !== 1'b1 || rdy4 !== 1'b1) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("final_idle", {rdy1, rdy4}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
